// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy states,
// count width and standard bubble (NOP) encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned CNT_W = 2;

  localparam logic [31:0] NOP_MIPS  = 32'h0000_0000;
  localparam logic [31:0] NOP_RISCV = 32'h0000_0013;

  function automatic logic [CNT_W-1:0] state_count(input pipe_state_e s);
    case (s)
      PS_BUSY: return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Single payload register: async reset and sync clear both load BUBBLE;
// clear takes priority over load.
module pipe_slot #(
  parameter int unsigned           WIDTH  = 32,
  parameter logic [WIDTH-1:0]      BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= BUBBLE;
    else if (clr) q <= BUBBLE;
    else if (ld)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer
// and synchronous flush to a bubble value.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  pipe_state_e      state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [CNT_W-1:0] count_q;
  logic             in_fire, out_fire;
  logic             main_ld, main_clr, skid_ld, skid_clr, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d  = PS_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            main_ld = 1'b1;
            state_d = PS_BUSY;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = PS_EMPTY;
          end else if (in_fire) begin
            skid_ld = 1'b1;
            state_d = PS_FULL;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = PS_BUSY;
          end
        end
        default: begin
          state_d  = PS_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // Handshake outputs are decoded from the next state into their own flops,
  // so in_ready/out_valid/count come straight off a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != PS_FULL);
      out_valid_q <= (state_d != PS_EMPTY);
      count_q     <= state_count(state_d);
    end
  end

  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .clr (main_clr),
    .d   (main_d),
    .q   (out_data)
  );

  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .clr (skid_clr),
    .d   (in_data),
    .q   (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and provides full throughput under back-pressure. It registers the ready path so stall signals no longer ripple combinationally through the whole pipeline. Flush squashes the stage to a configurable bubble value for branch and exception recovery.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1).
- BUBBLE, {WIDTH{1'b0}}, payload value loaded on reset and on flush (a NOP encoding for instruction-carrying stages).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream offers in_data.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  stage can accept this cycle; driven directly from a flop, with no combinational path from any input.
- out_valid  output  1  out_data holds a valid entry; registered.
- out_data  output  WIDTH  payload to downstream; registered.
- out_ready  input  1  downstream accepts this cycle.
- count  output  2  entries held (0, 1 or 2); registered.

## Operation
- Storage: main slot (drives out_data) and skid slot. State is EMPTY (0 entries), BUSY (main valid) or FULL (main and skid valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL). out_valid = (state != EMPTY). count = 0/1/2 for EMPTY/BUSY/FULL.
- Transitions, evaluated only when flush = 0:
  - EMPTY with in_fire: main ← in_data, go to BUSY. Otherwise stay in EMPTY.
  - BUSY with in_fire & out_fire: main ← in_data, stay in BUSY.
  - BUSY with out_fire only: go to EMPTY. main ← BUBBLE.
  - BUSY with in_fire only: skid ← in_data, go to FULL.
  - BUSY with neither: hold.
  - FULL with out_fire: main ← skid, skid ← BUBBLE, go to BUSY. in_valid is ignored because in_ready = 0.
  - FULL without out_fire: hold.
- flush = 1 has priority over every handshake in the same cycle:
  - Next state is EMPTY, and main and skid are both set to BUBBLE.
  - An in_fire in that cycle is discarded, and upstream sees it as accepted.
  - An out_fire in that cycle is still consumed by downstream.
- Ordering: strict FIFO. No entry is ever duplicated or dropped except by flush.
- Payload is opaque. There is no arithmetic on the data, only on the 2-bit count.

## Timing
- Reset values while rst is high and after release: state EMPTY, out_valid 0, in_ready 1, count 0, out_data BUBBLE, skid BUBBLE.
- Reset is asynchronous and may be asserted mid-transfer. Any held entries are lost, with no partial-update glitch on outputs beyond the async clear.
- Latency: an entry accepted on edge N is visible on out_data and out_valid after edge N. That gives 1 cycle of latency from the EMPTY or BUSY pass-through state.
- Throughput: 1 transfer per cycle when out_ready is held high, with no bubbles.
- Back-pressure: when out_ready drops, the stage absorbs exactly one more entry (the skid). in_ready falls after the next edge, not combinationally.
- After flush is asserted on edge N: out_valid = 0, count = 0 and in_ready = 1 from edge N.

## Structure
- Shared package `pipe_pkg`:
  - State enum: PS_EMPTY, PS_BUSY, PS_FULL, encoded on 2 bits.
  - Constant for the count width.
  - Standard BUBBLE constants, e.g. the MIPS NOP value 32'h0000_0000.
- One sub-module, `pipe_slot`:
  - A WIDTH-bit register with asynchronous reset to BUBBLE, a load enable and a synchronous clear to BUBBLE.
  - Instantiated twice, once for main and once for skid.
- The top-level module holds the state register and the next-state/load-select logic.

## Test plan
- Streaming: out_ready = 1, send 0x11, 0x22 and 0x33 on consecutive cycles. out_data shows 0x11, 0x22, 0x33 on the following three cycles, in_ready stays 1 and count stays 1.
- Back-pressure: out_ready = 0, send 0xA and 0xB. count goes 1 then 2, in_ready goes to 0 and a third offer of 0xC is held. Raise out_ready: the outputs are 0xA, then 0xB, then 0xC, with nothing lost.
- Flush while FULL: FULL holding 0xA/0xB, assert flush with in_valid = 1 and in_data = 0xC. Next cycle shows count 0, out_valid 0, out_data = BUBBLE and in_ready 1, and 0xC never appears.
- Simultaneous in_fire and out_fire in BUSY: the main slot is replaced by the new entry in one cycle and count stays 1.
- Asynchronous reset mid-stream while FULL: outputs clear immediately without waiting for a clock edge (out_valid 0, count 0, in_ready 1). The first transfer after release has 1-cycle latency.
- Random scoreboard: random in_valid, out_ready and occasional flush over 10k cycles. The output sequence matches a reference queue that is cleared on flush, and no handshake rule is violated.
